// File: rtl/cpu_trace_pkg.sv
// Shared types and layout helpers for the CPU instruction-trace buffer.
package cpu_trace_pkg;

  // Capture state machine states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // Trigger source select values for trig_mode.
  localparam logic TRIG_PC = 1'b0;
  localparam logic TRIG_OP = 1'b1;

  // Offset of the result field inside a packed entry (least significant).
  localparam int OFF_RESULT = 0;

  // Packed entry width: {pc, op, rd, result}.
  function automatic int entry_w(input int addr_w, input int op_w, input int data_w);
    return addr_w + (2 * op_w) + data_w;
  endfunction

  // Offset of the destination-register field.
  function automatic int off_rd(input int data_w);
    return data_w;
  endfunction

  // Offset of the opcode field.
  function automatic int off_op(input int op_w, input int data_w);
    return data_w + op_w;
  endfunction

  // Offset of the PC field (most significant).
  function automatic int off_pc(input int op_w, input int data_w);
    return data_w + (2 * op_w);
  endfunction

endpackage

// File: rtl/trace_mem.sv
// Trace storage: DEPTH x W register array with one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module trace_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 40
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Store one entry on each enabled rising edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture: circular pre-trigger history, PC/opcode trigger,
// programmable post-trigger window, then frozen oldest-first readout.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int OP_W      = 4,
  parameter int DEPTH     = 8,
  parameter int POST_TRIG = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trig_mode,
  input  logic [ADDR_W-1:0]        trig_pc,
  input  logic [OP_W-1:0]          trig_op,
  input  logic                     force_trig,
  input  logic                     valid,
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic [OP_W-1:0]          op_in,
  input  logic [OP_W-1:0]          rd_in,
  input  logic [DATA_W-1:0]        result_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [OP_W-1:0]          out_op,
  output logic [OP_W-1:0]          out_rd,
  output logic [DATA_W-1:0]        out_result,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     armed,
  output logic                     triggered,
  output logic                     overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_w(ADDR_W, OP_W, DATA_W);
  localparam int OFF_RD  = off_rd(DATA_W);
  localparam int OFF_OP  = off_op(OP_W, DATA_W);
  localparam int OFF_PC  = off_pc(OP_W, DATA_W);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
  localparam logic [PTR_W-1:0] POST_INI = PTR_W'(POST_TRIG);

  trace_state_e       state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   post_cnt_q, post_cnt_d;
  logic               overflow_q, overflow_d;

  logic               we_s;
  logic               full_s;
  logic               trig_hit_s;
  logic [PTR_W-1:0]   rd_ptr_s;
  logic [ENTRY_W-1:0] wdata_s;
  logic [ENTRY_W-1:0] rdata_s;

  assign full_s     = (count_q == FULL_CNT);
  assign trig_hit_s = valid && (force_trig ||
                      ((trig_mode == TRIG_OP) ? (op_in == trig_op) : (pc_in == trig_pc)));
  // Oldest entry sits count positions behind the write pointer; a full
  // buffer (count == DEPTH) therefore reads back at wr_ptr itself.
  assign rd_ptr_s   = wr_ptr_q - count_q[PTR_W-1:0];
  assign wdata_s    = {pc_in, op_in, rd_in, result_in};

  trace_mem #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_s),
    .raddr_i (rd_ptr_s),
    .rdata_o (rdata_s)
  );

  // State, pointers, occupancy and sticky overflow registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: abort overrides everything, then per-state handling.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    overflow_d = overflow_q;
    we_s       = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            state_d    = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_ARMED: begin
          if (valid) begin
            we_s     = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE_PTR;
            if (full_s) begin
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + ONE_CNT;
            end
            if (trig_hit_s) begin
              if (POST_TRIG == 0) begin
                state_d = ST_DONE;
              end else begin
                post_cnt_d = POST_INI;
                state_d    = ST_POST;
              end
            end else begin
              state_d = ST_ARMED;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end

        ST_POST: begin
          // Post-trigger writes can only evict pre-trigger history, since the
          // trigger entry plus the window never exceeds DEPTH entries.
          if (valid) begin
            we_s       = 1'b1;
            wr_ptr_d   = wr_ptr_q + ONE_PTR;
            post_cnt_d = post_cnt_q - ONE_PTR;
            if (full_s) begin
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + ONE_CNT;
            end
            if (post_cnt_q == ONE_PTR) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
            end
          end else begin
            state_d = ST_POST;
          end
        end

        ST_DONE: begin
          if (count_q == '0) begin
            state_d = ST_IDLE;
          end else if (out_ready) begin
            count_d = count_q - ONE_CNT;
            if (count_q == ONE_CNT) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_DONE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign armed     = (state_q == ST_ARMED);
  assign triggered = (state_q == ST_POST) || (state_q == ST_DONE);
  assign out_valid = (state_q == ST_DONE) && (count_q != '0);

  // Readout fields are held at zero whenever no entry is being offered, so the
  // uninitialised storage never leaks onto the port.
  assign out_pc     = out_valid ? rdata_s[OFF_PC +: ADDR_W]     : '0;
  assign out_op     = out_valid ? rdata_s[OFF_OP +: OP_W]       : '0;
  assign out_rd     = out_valid ? rdata_s[OFF_RD +: OP_W]       : '0;
  assign out_result = out_valid ? rdata_s[OFF_RESULT +: DATA_W] : '0;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer with a queue-based reference model.
module tb_cpu_trace_buffer;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int OP_W      = 4;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 2;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_POST  = 2;
  localparam int P_DONE  = 3;

  logic              CLK;
  logic              RESET;
  logic              arm, abort, trig_mode, force_trig, valid, out_ready;
  logic [ADDR_W-1:0] trig_pc, pc_in;
  logic [OP_W-1:0]   trig_op, op_in, rd_in;
  logic [DATA_W-1:0] result_in;
  logic              out_valid, armed, triggered, overflow;
  logic [ADDR_W-1:0] out_pc;
  logic [OP_W-1:0]   out_op, out_rd;
  logic [DATA_W-1:0] out_result;
  logic [CNT_W-1:0]  count;

  cpu_trace_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .CLK(CLK), .RESET(RESET), .arm(arm), .abort(abort), .trig_mode(trig_mode),
    .trig_pc(trig_pc), .trig_op(trig_op), .force_trig(force_trig), .valid(valid),
    .pc_in(pc_in), .op_in(op_in), .rd_in(rd_in), .result_in(result_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_rd(out_rd), .out_result(out_result), .count(count), .armed(armed),
    .triggered(triggered), .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [OP_W-1:0]   op;
    logic [OP_W-1:0]   rd;
    logic [DATA_W-1:0] res;
  } rec_t;

  // Reference model: captured history as a bounded queue, oldest at index 0.
  rec_t mq[$];
  int   m_phase;
  bit   m_ovf;
  int   m_post_left;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_reset();
    mq.delete();
    m_phase     = P_IDLE;
    m_ovf       = 1'b0;
    m_post_left = 0;
  endfunction

  // Applies the inputs present just before a rising edge to the model.
  function automatic void model_edge();
    rec_t r;
    bit   hit;
    r.pc  = pc_in;
    r.op  = op_in;
    r.rd  = rd_in;
    r.res = result_in;
    hit   = valid && (force_trig || (trig_mode ? (op_in == trig_op) : (pc_in == trig_pc)));
    if (RESET) begin
      model_reset();
    end else if (abort) begin
      m_phase = P_IDLE;
      mq.delete();
    end else if (m_phase == P_IDLE) begin
      if (arm) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_phase = P_ARMED;
      end
    end else if (m_phase == P_ARMED || m_phase == P_POST) begin
      if (valid) begin
        mq.push_back(r);
        if (mq.size() > DEPTH) begin
          mq.delete(0);
          m_ovf = 1'b1;
        end
        if (m_phase == P_ARMED) begin
          if (hit) begin
            if (POST_TRIG == 0) m_phase = P_DONE;
            else begin
              m_post_left = POST_TRIG;
              m_phase     = P_POST;
            end
          end
        end else begin
          m_post_left = m_post_left - 1;
          if (m_post_left == 0) m_phase = P_DONE;
        end
      end
    end else begin
      if (mq.size() > 0 && out_ready) mq.delete(0);
      if (mq.size() == 0) m_phase = P_IDLE;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_quiet();
    arm = 1'b0; abort = 1'b0; force_trig = 1'b0; valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic retire(input int pc, input int op);
    pc_in     = ADDR_W'(pc);
    op_in     = OP_W'(op);
    rd_in     = OP_W'($urandom_range(0, 15));
    result_in = DATA_W'($urandom);
    valid     = 1'b1;
    tick();
    valid     = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    drive_quiet();
    trig_mode = 1'b0; trig_pc = '0; trig_op = '0;
    pc_in = '0; op_in = '0; rd_in = '0; result_in = '0;
    model_reset();
    #1;
    n_checks++;
    if ({out_valid, armed, triggered, overflow} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got v/a/t/o=%b%b%b%b, expected 0000", out_valid, armed, triggered, overflow);
    end
    n_checks++;
    if (count !== '0 || out_pc !== '0 || out_result !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got count=%0d pc=%0d res=%0d, expected 0/0/0", count, out_pc, out_result);
    end
    valid = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    RESET = 1'b0;
    tick();
    n_checks++;
    if (count !== '0 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got count=%0d armed=%b, expected 0/0", count, armed);
    end
  endtask

  task automatic test_pc_trigger();
    trig_mode = 1'b0; trig_pc = ADDR_W'(5);
    arm_pulse();
    for (int p = 0; p < 8; p++) begin
      retire(p, $urandom_range(0, 15));
      if (p == 6) begin
        n_checks++;
        if (triggered !== 1'b1 || out_valid !== 1'b0 || count !== CNT_W'(7)) begin
          n_fail++;
          $display("FAIL t1_post: got trig=%b ov=%b count=%0d, expected 1/0/7", triggered, out_valid, count);
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || count !== CNT_W'(8) || overflow !== 1'b0 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_done: got ov=%b count=%0d ovf=%b armed=%b, expected 1/8/0/0", out_valid, count, overflow, armed);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== ADDR_W'(i) || mq.size() == 0 ||
          {out_op, out_rd, out_result} !== {mq[0].op, mq[0].rd, mq[0].res}) begin
        n_fail++;
        $display("FAIL t1_drain[%0d]: got v=%b pc=%0d op=%h rd=%h res=%h, expected pc=%0d", i, out_valid, out_pc, out_op, out_rd, out_result, i);
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || count !== '0 || triggered !== 1'b0 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_idle: got v=%b count=%0d trig=%b armed=%b, expected 0/0/0/0", out_valid, count, triggered, armed);
    end
  endtask

  task automatic test_overflow();
    trig_mode = 1'b0; trig_pc = ADDR_W'(9);
    arm_pulse();
    for (int p = 0; p < 12; p++) retire(p, $urandom_range(0, 15));
    n_checks++;
    if (overflow !== 1'b1 || count !== CNT_W'(8) || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL t2_done: got ovf=%b count=%0d v=%b, expected 1/8/1", overflow, count, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== ADDR_W'(i + 4) || mq.size() == 0 ||
          {out_op, out_rd, out_result} !== {mq[0].op, mq[0].rd, mq[0].res}) begin
        n_fail++;
        $display("FAIL t2_drain[%0d]: got v=%b pc=%0d, expected 1/%0d", i, out_valid, out_pc, i + 4);
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || triggered !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_idle: got v=%b trig=%b, expected 0/0", out_valid, triggered);
    end
  endtask

  task automatic test_op_trigger();
    int popped;
    trig_mode = 1'b1; trig_op = 4'hA; trig_pc = '0;
    arm_pulse();
    retire($urandom_range(1, 100), $urandom_range(0, 9));
    retire($urandom_range(1, 100), $urandom_range(0, 9));
    retire($urandom_range(1, 100), 10);
    for (int seg = 0; seg < 2; seg++) begin
      for (int g = 0; g < 3; g++) begin
        tick();
        n_checks++;
        if (triggered !== 1'b1 || out_valid !== 1'b0 || count !== CNT_W'(3 + seg)) begin
          n_fail++;
          $display("FAIL t3_gap[%0d.%0d]: got trig=%b v=%b count=%0d, expected 1/0/%0d", seg, g, triggered, out_valid, count, 3 + seg);
        end
      end
      retire($urandom_range(1, 100), 10);
    end
    retire($urandom_range(1, 100), $urandom_range(0, 15));
    n_checks++;
    if (count !== CNT_W'(5) || out_valid !== 1'b1 || triggered !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_done: got count=%0d v=%b trig=%b, expected 5/1/1", count, out_valid, triggered);
    end
    out_ready = 1'b1;
    popped = 0;
    for (int c = 0; c < 10 && out_valid === 1'b1; c++) begin
      n_checks++;
      if (mq.size() == 0 || {out_pc, out_op, out_rd, out_result} !== mq[0]) begin
        n_fail++;
        $display("FAIL t3_drain[%0d]: got pc=%0d op=%h, expected entry from model", c, out_pc, out_op);
      end
      if (c == 2) begin
        n_checks++;
        if (out_op !== 4'hA) begin
          n_fail++;
          $display("FAIL t3_trig_entry: got op=%h, expected a", out_op);
        end
      end
      popped++;
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (popped != 5 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_count: got %0d entries v=%b, expected 5 then 0", popped, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int exp_idx;
    trig_mode = 1'b0; trig_pc = ADDR_W'(5);
    arm_pulse();
    for (int p = 0; p < 8; p++) retire(p, $urandom_range(0, 15));
    exp_idx = 0;
    for (int c = 0; c < 60 && exp_idx < 8; c++) begin
      out_ready = (c < 4) ? pat[c] : ((c < 20) ? 1'($urandom_range(0, 1)) : 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== ADDR_W'(exp_idx) || count !== CNT_W'(8 - exp_idx)) begin
        n_fail++;
        $display("FAIL t4_bp[%0d]: got v=%b pc=%0d count=%0d, expected 1/%0d/%0d", c, out_valid, out_pc, count, exp_idx, 8 - exp_idx);
      end
      if (out_ready) exp_idx++;
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (exp_idx != 8 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_end: got %0d entries v=%b, expected 8 then 0", exp_idx, out_valid);
    end
  endtask

  task automatic test_abort();
    trig_mode = 1'b0; trig_pc = ADDR_W'(9);
    arm_pulse();
    for (int p = 0; p < 12; p++) retire(p, $urandom_range(0, 15));
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || count !== '0 || triggered !== 1'b0 || armed !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_abort: got v=%b count=%0d trig=%b armed=%b ovf=%b, expected 0/0/0/0/1", out_valid, count, triggered, armed, overflow);
    end
    arm_pulse();
    n_checks++;
    if (armed !== 1'b1 || overflow !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL t5_rearm: got armed=%b ovf=%b count=%0d, expected 1/0/0", armed, overflow, count);
    end
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_abort_arm: got armed=%b, expected 0", armed);
    end
  endtask

  task automatic test_reset_mid_post();
    trig_mode = 1'b0; trig_pc = ADDR_W'(5);
    arm_pulse();
    for (int p = 0; p < 6; p++) retire(p, $urandom_range(0, 15));
    n_checks++;
    if (triggered !== 1'b1 || count !== CNT_W'(6)) begin
      n_fail++;
      $display("FAIL t6_post: got trig=%b count=%0d, expected 1/6", triggered, count);
    end
    #2 RESET = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({out_valid, armed, triggered, overflow} !== 4'b0000 || count !== '0 || out_pc !== '0) begin
      n_fail++;
      $display("FAIL t6_async: got v/a/t/o=%b%b%b%b count=%0d pc=%0d, expected all 0", out_valid, armed, triggered, overflow, count, out_pc);
    end
    #2 RESET = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) retire(i, $urandom_range(0, 15));
    n_checks++;
    if (count !== '0 || armed !== 1'b0 || triggered !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_ignore: got count=%0d armed=%b trig=%b, expected 0/0/0", count, armed, triggered);
    end
    arm_pulse();
    retire(1, 0);
    n_checks++;
    if (count !== CNT_W'(1) || armed !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_restart: got count=%0d armed=%b, expected 1/1", count, armed);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_random();
    bit exp_v;
    for (int c = 0; c < 800; c++) begin
      arm        = ($urandom_range(0, 9) == 0);
      abort      = ($urandom_range(0, 49) == 0);
      trig_mode  = 1'($urandom_range(0, 1));
      trig_pc    = ADDR_W'($urandom_range(0, 15));
      trig_op    = OP_W'($urandom_range(0, 15));
      force_trig = ($urandom_range(0, 19) == 0);
      valid      = ($urandom_range(0, 9) < 7);
      pc_in      = ADDR_W'($urandom_range(0, 15));
      op_in      = OP_W'($urandom_range(0, 15));
      rd_in      = OP_W'($urandom_range(0, 15));
      result_in  = DATA_W'($urandom);
      out_ready  = ($urandom_range(0, 9) < 6);
      tick();
      exp_v = (m_phase == P_DONE) && (mq.size() > 0);
      n_checks++;
      if (count !== CNT_W'(mq.size()) || out_valid !== exp_v || armed !== (m_phase == P_ARMED) ||
          triggered !== (m_phase == P_POST || m_phase == P_DONE) || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL rnd_status[%0d]: got count=%0d v=%b a=%b t=%b o=%b, expected %0d/%b/%b/%b/%b", c, count, out_valid, armed, triggered, overflow,
                 mq.size(), exp_v, (m_phase == P_ARMED), (m_phase == P_POST || m_phase == P_DONE), m_ovf);
      end
      if (exp_v) begin
        n_checks++;
        if ({out_pc, out_op, out_rd, out_result} !== mq[0]) begin
          n_fail++;
          $display("FAIL rnd_data[%0d]: got pc=%0d op=%h rd=%h res=%h, expected pc=%0d op=%h rd=%h res=%h", c, out_pc, out_op, out_rd, out_result,
                   mq[0].pc, mq[0].op, mq[0].rd, mq[0].res);
        end
      end
    end
    drive_quiet();
  endtask

  initial begin
    test_reset();
    test_pc_trigger();
    test_overflow();
    test_op_trigger();
    test_back_to_back();
    test_abort();
    test_reset_mid_post();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised instruction-trace capture block for the 16-bit single-cycle CPU. It records retired-instruction records (PC, opcode, destination register, result) into a circular buffer, triggers on a PC or opcode match, and then captures a programmable post-trigger window. After capture it freezes and drains oldest-first over a valid/ready port, for use by the testbench and the debug hardware.

Parameters:
DATA_W, 16, width of result_in/out_result
ADDR_W, 16, width of PC fields
OP_W, 4, width of opcode and register-index fields
DEPTH, 8, buffer entries; power of 2, >= 2
POST_TRIG, 2, entries captured after the trigger entry; 0 <= POST_TRIG <= DEPTH-1

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
arm  in  1  pulse; starts a capture, honoured only in IDLE
abort  in  1  pulse; returns to IDLE from any state and discards contents
trig_mode  in  1  0 = PC match, 1 = opcode match
trig_pc  in  ADDR_W  PC compare value
trig_op  in  OP_W  opcode compare value
force_trig  in  1  unconditional trigger, qualified by valid
valid  in  1  retire strobe; record inputs are sampled when high
pc_in  in  ADDR_W  retired PC
op_in  in  OP_W  retired opcode
rd_in  in  OP_W  destination register
result_in  in  DATA_W  ALU/writeback result
out_valid  out  1  readout entry available
out_ready  in  1  consumer accepts entry
out_pc/out_op/out_rd/out_result  out  ADDR_W/OP_W/OP_W/DATA_W  oldest unread entry
count  out  log2(DEPTH)+1  entries held
armed  out  1  state == ARMED
triggered  out  1  state == POST or DONE
overflow  out  1  a pre-trigger entry was overwritten

Behaviour:
- States: IDLE, ARMED, POST, DONE. On reset: state IDLE; all outputs, wr_ptr, count and post_cnt are 0.
- IDLE: valid is ignored. On arm: wr_ptr=0, count=0, overflow=0, next state ARMED.
- ARMED: each valid writes the entry at wr_ptr and increments wr_ptr mod DEPTH.
  - count increments and saturates at DEPTH.
  - A write while count==DEPTH sets overflow (sticky until the next arm).
- Trigger: valid && (force_trig || (trig_mode ? op_in==trig_op : pc_in==trig_pc)), evaluated only in ARMED.
  - The triggering entry is written.
  - If POST_TRIG==0, next state DONE; otherwise post_cnt=POST_TRIG and next state POST.
- POST: each valid writes as in ARMED and decrements post_cnt. The write that takes post_cnt to 0 moves to DONE. Cycles with valid low do not count. Triggers are ignored.
- DONE: valid is ignored.
  - out_valid = (count != 0).
  - out_* are combinational from entry rd_ptr = (wr_ptr - count) mod DEPTH.
  - On out_valid && out_ready: count decrements at the clock edge and the next entry appears in the following cycle. One entry per cycle is sustainable.
  - When count reaches 0: next state IDLE and out_valid low.
- abort: has priority over all other events, including arm, trigger and pop in the same cycle. It sets state IDLE and count=0, and leaves overflow unchanged.
- arm outside IDLE is ignored.
- out_valid is 0 in every state except DONE.
- RESET asserted mid-capture or mid-readout: immediate return to reset values. Buffer contents are don't-care.
- Pointer arithmetic wraps modulo DEPTH. count never exceeds DEPTH.

Decomposition:
- Package cpu_trace_pkg:
  - state enum (IDLE, ARMED, POST, DONE)
  - TRIG_PC=0 / TRIG_OP=1 constants
  - ENTRY_W = ADDR_W+2*OP_W+DATA_W function/constant
  - entry field offsets
- Sub-module trace_mem: DEPTH x ENTRY_W register array, synchronous write port, asynchronous read port, no reset on storage.

Test Plan:
1. DEPTH=8, POST_TRIG=2, trig_mode=0, trig_pc=5. Arm, then retire pc=0..7 on consecutive cycles. Required: DONE after pc=7, count=8, overflow=0. Draining with out_ready=1 yields pc 0,1,...,7, then out_valid=0 and state IDLE.
2. Same setup with trig_pc=9 and pc=0..11. Required: overflow=1, count=8, readout pc 4..11 in order.
3. trig_mode=1, trig_op=4'hA, POST_TRIG=2. Opcode 4'hA arrives at the third retire, and valid is held low for 3 cycles between the post-trigger retires. Required: exactly 2 post entries captured, count=5, triggered held high through the gaps.
4. Readout backpressure: toggle out_ready 1,0,0,1 in DONE. Required: out_pc changes only after cycles with out_ready=1, and no entry is duplicated or skipped.
5. abort and out_ready high in the same DONE cycle. Required: next cycle state IDLE, count=0, out_valid=0. A subsequent arm restarts with overflow=0.
6. RESET asserted asynchronously mid-POST, between clock edges. Required: all outputs 0 immediately. After release, valid retires are ignored until arm.
